// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed, double-buffered scan controller for an NDIG-digit common-anode 7-segment display.
// Optional leading-zero suppression is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              blank,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        a_to_g,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NDIG);

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic              boundary;
  logic [4*NDIG-1:0] disp_p0;
  logic [4*NDIG-1:0] pend_p0;
  logic              pend_vld_p0;
  logic [3:0]        nib;
  logic [NDIG-1:0]   an_nxt;
  logic              dark;
  logic [NDIG-1:0]   an_p1;
  logic [6:0]        seg_p1;
  logic              frame_done_p1;

  assign tick     = (cnt == CNT_W'(PRESCALE - 1));
  assign boundary = tick && (idx == IDX_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) idx <= boundary ? '0 : idx + IDX_W'(1);
    end
  end

  // p0: pending buffer and display register; commit only at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_p0     <= '0;
      pend_p0     <= '0;
      pend_vld_p0 <= 1'b0;
    end else begin
      if (load) pend_p0 <= value;
      if (boundary) begin
        if (load)             disp_p0 <= value;
        else if (pend_vld_p0) disp_p0 <= pend_p0;
        pend_vld_p0 <= 1'b0;
      end else if (load) begin
        pend_vld_p0 <= 1'b1;
      end
    end
  end

  assign nib = disp_p0[4*idx +: 4];

  always_comb begin
    an_nxt      = '1;
    an_nxt[idx] = 1'b0;
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NDIG-1:0] lz_dark;
  logic            zero_run;

  // Digit k goes dark when it and every more-significant nibble are zero; digit 0 never does.
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      zero_run   = zero_run & (disp_p0[4*k +: 4] == 4'h0);
      lz_dark[k] = zero_run;
    end
  end

  assign dark = blank | lz_dark[idx];
`else
  assign dark = blank;
`endif

  // p1: registered pin drivers, trailing idx by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1         <= '1;
      seg_p1        <= '1;
      frame_done_p1 <= 1'b0;
    end else begin
      an_p1         <= dark ? '1 : an_nxt;
      seg_p1        <= dark ? '1 : seg7_decode(nib);
      frame_done_p1 <= boundary;
    end
  end

  assign an         = an_p1;
  assign a_to_g     = seg_p1;
  assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NDIG=4, PRESCALE=4); expectations follow SEG7_LZ_BLANK_EN when defined.
module tb_seg7_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = NDIG * PRESCALE;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  exp_t q[$];

  seg7_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank(blank),
    .an(an), .a_to_g(a_to_g), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic exp_t exp_digit(input logic [15:0] d, input int k);
    exp_t e;
    logic dark;
    dark = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (k > 0) begin
      dark = 1'b1;
      for (int j = k; j < NDIG; j++) if (d[4*j +: 4] != 4'h0) dark = 1'b0;
    end
`endif
    e.an    = 4'hF;
    e.an[k] = 1'b0;
    e.seg   = seg_of(d[4*k +: 4]);
    if (dark) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue one expected {an,a_to_g} per cycle of the coming frame; cycles bfrom..bto blanked.
  task automatic push_frame(input logic [15:0] d, input int bfrom, input int bto);
    exp_t e;
    for (int c = 0; c < FRAME; c++) begin
      e = exp_digit(d, c / PRESCALE);
      if (c >= bfrom && c <= bto) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_frame(output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    if (frame_done !== 1'b1) check("frame_done timeout", {31'b0, frame_done}, 32'h1);
    at = cyc_n;
  endtask

  // Checks the first frame after reset release (display register must read 0).
  task automatic post_reset_scan(input string tag);
    exp_t e;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      e = exp_digit(16'h0, c / PRESCALE);
      check($sformatf("%s an c%0d", tag, c), an, e.an);
      check($sformatf("%s seg c%0d", tag, c), a_to_g, e.seg);
      if (c == 0)         check($sformatf("%s fd low", tag), frame_done, 0);
      if (c == FRAME - 1) check($sformatf("%s fd pulse", tag), frame_done, 1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    @(negedge clk);
    forever begin
      if (frame_done === 1'b1) begin
        #1;
        if (q.size() >= FRAME) begin
          for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("scan an c%0d", c), an, e.an);
            check($sformatf("scan seg c%0d", c), a_to_g, e.seg);
          end
        end else begin
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : stimulus
    int t0, t1;
    repeat (3) @(negedge clk);
    check("reset an", an, 4'hF);
    check("reset seg", a_to_g, 7'h7F);
    check("reset fd", frame_done, 0);
    rst_n = 1'b1;
    post_reset_scan("init");
    t0 = cyc_n;

    push_frame(16'h0000, -1, -1);
    repeat (5) @(negedge clk);
    value = 16'h3210; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(t1); check("cadence decode", t1 - t0, FRAME); t0 = t1;

    push_frame(16'h3210, -1, -1);
    repeat (5) @(negedge clk);
    value = 16'h1111; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(t1); check("cadence 1111", t1 - t0, FRAME); t0 = t1;

    // Load lands in slot 1; digits 2 and 3 must keep showing 1 this frame.
    push_frame(16'h1111, -1, -1);
    repeat (5) @(negedge clk);
    value = 16'hABCD; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(t1); check("cadence tear", t1 - t0, FRAME); t0 = t1;

    push_frame(16'hABCD, -1, -1);
    repeat (9) @(negedge clk);
    value = 16'h0005; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (5) @(negedge clk);
    value = 16'h0009; load = 1'b1;
    wait_frame(t1); load = 1'b0;
    check("cadence boundary load", t1 - t0, FRAME); t0 = t1;

    push_frame(16'h0009, -1, -1);
    wait_frame(t1); check("cadence pend clr", t1 - t0, FRAME); t0 = t1;

    push_frame(16'h0009, 3, 10);
    repeat (3) @(negedge clk);
    blank = 1'b1;
    repeat (8) @(negedge clk);
    blank = 1'b0;
    wait_frame(t1); check("cadence blank", t1 - t0, FRAME); t0 = t1;

    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst an", an, 4'hF);
    check("async rst seg", a_to_g, 7'h7F);
    check("async rst fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    post_reset_scan("midrst");
    t0 = cyc_n;

    repeat (5) @(negedge clk);
    value = 16'h0070; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(t1); check("cadence 0070", t1 - t0, FRAME); t0 = t1;

    push_frame(16'h0070, -1, -1);
    repeat (5) @(negedge clk);
    value = 16'h0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(t1); check("cadence 0000", t1 - t0, FRAME); t0 = t1;

    push_frame(16'h0000, -1, -1);
    wait_frame(t1);
    repeat (2) @(negedge clk);
    check("queue drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
- Shares a single hex-to-segment decode path across all digits, one digit per scan slot.
- Double-buffers the displayed value so a host update never tears mid-frame.
- Sits between the host's value register and the board's anode/segment pins.

Parameters:
- NDIG, 4, number of digits scanned; legal range 2..8.
- PRESCALE, 50000, clk cycles per digit slot; legal range ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value  input  4*NDIG  hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
- load  input  1  one-cycle strobe that captures value into the pending buffer.
- blank  input  1  level; 1 forces the display dark while the scan keeps running.
- an  output  NDIG  anode enables, active-low, one-hot-low while a digit is lit.
- a_to_g  output  7  segments {a,b,c,d,e,f,g}, msb=a, active-low.
- frame_done  output  1  one-cycle pulse when digit NDIG-1's slot ends.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - Prescaler cnt=0, digit index idx=0, display register=0, pending register=0, pending flag=0.
  - an=all ones, a_to_g=7'b1111111, frame_done=0.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 when cnt==PRESCALE-1.
- Digit index:
  - On tick, idx advances by 1.
  - At idx==NDIG-1 with tick, idx wraps to 0 and a frame boundary occurs.
- frame_done: registered; high for exactly the one cycle after the boundary edge.
- Load handshake:
  - load=1 copies value into the pending register and sets the pending flag.
  - A later load before the boundary overwrites the pending register (last one wins).
- Commit at the frame boundary edge:
  - If load=1 in the boundary cycle, value is written straight into the display register.
  - Else, if the pending flag is set, the pending register is written into the display register.
  - In both cases the pending flag clears.
  - With no load and no pending flag, the display register holds.
- Output pipeline:
  - an and a_to_g are registered from idx and the display nibble, so they trail idx by 1 cycle.
  - an[idx]=0 and all other bits=1.
  - a_to_g = decode(display nibble idx).
- Decode table, active-low, hex 0..F:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blank:
  - blank=1 registers an=all ones and a_to_g=1111111 on the next edge.
  - cnt, idx, load and commit behave exactly as when blank=0.
- Reset mid-frame: all state returns immediately to reset values; pending data is lost.
- After reset release, the first lit output is digit 0, one cycle after release.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit k>0 is dark (an[k]=1, a_to_g=1111111) when nibbles NDIG-1..k of the display register are all 0.
  - Digit 0 is always shown.
  - Suppression is evaluated in the same registered stage, so there is no added latency.
- Undefined: all digits are always shown; the logic is absent.

Test Plan (NDIG=4, PRESCALE=4):
- Reset/scan:
  - Stimulus: hold rst_n=0, then release.
  - Required: an=1111 and a_to_g=1111111 while in reset.
  - Required: after release, an steps 1110→1101→1011→0111, 4 cycles each.
  - Required: frame_done pulses every 16 cycles.
- Decode:
  - Stimulus: load value=16'h3210, then wait one frame.
  - Required: digit0 a_to_g=0000001, digit1 1001111, digit2 0010010, digit3 0000110.
- Tear-free update:
  - Stimulus: display shows 16'h1111; load 16'hABCD mid-frame at idx=1.
  - Required: digits 2 and 3 still show 1 for the rest of the frame.
  - Required: the next frame shows A,B,C,D on digits 3..0.
- Simultaneous events:
  - Stimulus: load 16'h0005 at idx=2; load 16'h0009 in the boundary cycle.
  - Required: the next frame's digit0 shows 9 (0000100); the pending flag is cleared.
- Blank and reset mid-operation:
  - Stimulus: blank=1 for 8 cycles.
  - Required: outputs are dark; frame_done cadence is unchanged.
  - Stimulus: then pulse rst_n low mid-slot.
  - Required: outputs go dark asynchronously; the display register reads 0 afterwards.
- SEG7_LZ_BLANK_EN defined:
  - Stimulus: value=16'h0070.
  - Required: digits 3 and 2 are dark, digit1 shows 7, digit0 shows 0.
  - Stimulus: value=16'h0000.
  - Required: only digit0 is lit, showing 0.
